// File: rtl/led_gpio_sequencer_if.sv
// ----------------------------------------------------------------------------
// led_gpio_sequencer_if
// Bundles the CPU store path, the sequencer config write and the write port
// driven into the LED/GPIO device at 0xF000_0000.
//   cpu_we/cpu_wdata   CPU store to the device this cycle
//   cfg_we/cfg_wdata   sequencer config write ([1:0] mode)
//   gpio_we/gpio_wdata write strobe and word to the device
//   led_pattern        current engine pattern
//   pending            engine step computed but not yet written
//   mode               current sequencer mode
// master: bus side (drives requests). slave: the sequencer.
// ----------------------------------------------------------------------------
interface led_gpio_sequencer_if;
  logic        cpu_we;
  logic [31:0] cpu_wdata;
  logic        cfg_we;
  logic [7:0]  cfg_wdata;
  logic        gpio_we;
  logic [31:0] gpio_wdata;
  logic [7:0]  led_pattern;
  logic        pending;
  logic [1:0]  mode;

  modport master (
    output cpu_we, cpu_wdata, cfg_we, cfg_wdata,
    input  gpio_we, gpio_wdata, led_pattern, pending, mode
  );

  modport slave (
    input  cpu_we, cpu_wdata, cfg_we, cfg_wdata,
    output gpio_we, gpio_wdata, led_pattern, pending, mode
  );
endinterface

// File: rtl/led_gpio_sequencer.sv
// ----------------------------------------------------------------------------
// led_gpio_sequencer
// Owns the single write port of the LED/GPIO device. CPU stores pass straight
// through (highest priority); otherwise an LED pattern engine (walk / blink /
// count) writes a new LED image every TICK_DIV cycles. A shadow of the last
// word written lets engine writes replace only the LED field [9:2] while
// keeping GPIO bits [31:10] and counter_set [1:0].
// Ports:
//   clk   system clock, rising edge
//   rst_n synchronous active-low reset
//   bus   led_gpio_sequencer_if.slave (CPU/config requests, device write port)
// Parameters:
//   TICK_DIV clk cycles per pattern step (>= 2)
//   DIV_W    tick counter width, must hold TICK_DIV-1
// ----------------------------------------------------------------------------
module led_gpio_sequencer #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned DIV_W    = 25
) (
  input logic                 clk,
  input logic                 rst_n,
  led_gpio_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // mode 00, engine stopped
    RUN  = 2'd1,  // counting towards the next step
    PEND = 2'd2   // step ready, write slot held by another requester
  } state_t;

  localparam logic [7:0]  RST_LED  = 8'h2A;
  localparam logic [31:0] RST_WORD = {22'd0, RST_LED, 2'b00};

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [DIV_W-1:0]   tick_q, tick_d;
  logic [7:0]         pattern_q, pattern_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               pending_q, pending_d;

  logic               tick_last;
  logic               engine_step;
  logic               slot_busy;
  logic [7:0]         next_pat;
  logic [31:0]        engine_word;
  logic               unused_cfg;

  // Reserved config bits carry no meaning.
  assign unused_cfg = ^bus.cfg_wdata[7:2];

  // The CPU is the only other user of the write port and it discards the
  // step instead of delaying it, so nothing holds the slot today. Kept as a
  // hook for a future second requester that would park the step in PEND.
  assign slot_busy = 1'b0;

  function automatic logic [7:0] step_pattern(input logic [1:0] m,
                                              input logic [7:0] p);
    case (m)
      2'b01:   return (p == 8'h00) ? 8'h01 : {p[6:0], p[7]};  // walk
      2'b10:   return ~p;                                       // blink
      2'b11:   return p + 8'd1;                                 // count
      default: return p;
    endcase
  endfunction

  assign tick_last   = (tick_q == DIV_W'(TICK_DIV - 1));
  assign next_pat    = step_pattern(mode_q, pattern_q);
  assign engine_word = {shadow_q[31:10], next_pat, shadow_q[1:0]};
  assign engine_step = ((state_q == RUN) && tick_last) || (state_q == PEND);

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mode_d    = bus.cfg_we ? bus.cfg_wdata[1:0] : mode_q;
    tick_d    = tick_q;
    pattern_d = pattern_q;
    shadow_d  = shadow_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    pending_d = pending_q;

    // Write port: CPU first; an engine step coinciding with a CPU store or a
    // config write is dropped, never queued behind it.
    if (bus.cpu_we) begin
      we_d      = 1'b1;
      wdata_d   = bus.cpu_wdata;
      shadow_d  = bus.cpu_wdata;
      pattern_d = bus.cpu_wdata[9:2];
    end else if (engine_step && !bus.cfg_we && !slot_busy) begin
      we_d      = 1'b1;
      wdata_d   = engine_word;
      shadow_d  = engine_word;
      pattern_d = next_pat;
    end

    // Sequencing: any CPU store or config write restarts the step period.
    if (bus.cpu_we || bus.cfg_we) begin
      tick_d    = '0;
      pending_d = 1'b0;
      state_d   = (mode_d == 2'b00) ? IDLE : RUN;
    end else begin
      case (state_q)
        RUN: begin
          tick_d = tick_last ? '0 : tick_q + DIV_W'(1);
          if (tick_last && slot_busy) begin
            state_d   = PEND;
            pending_d = 1'b1;
          end
        end
        PEND: begin
          tick_d = tick_last ? '0 : tick_q + DIV_W'(1);
          if (!slot_busy) begin
            state_d   = RUN;
            pending_d = 1'b0;
          end
        end
        default: ;  // IDLE: hold
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is synchronous, checked on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 2'b00;
      tick_q    <= '0;
      pattern_q <= RST_LED;
      shadow_q  <= RST_WORD;
      wdata_q   <= RST_WORD;
      we_q      <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      pattern_q <= pattern_d;
      shadow_q  <= shadow_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      pending_q <= pending_d;
    end
  end

  assign bus.gpio_we     = we_q;
  assign bus.gpio_wdata  = wdata_q;
  assign bus.led_pattern = pattern_q;
  assign bus.pending     = pending_q;
  assign bus.mode        = mode_q;

endmodule

// File: tb/tb_led_gpio_sequencer.sv
// ----------------------------------------------------------------------------
// tb_led_gpio_sequencer
// Directed bench for led_gpio_sequencer with TICK_DIV=4. Inputs are driven
// 1 ns after the rising edge and outputs sampled there as well.
// ----------------------------------------------------------------------------
module tb_led_gpio_sequencer;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DIV_W    = 2;

  logic clk;
  logic rst_n;
  led_gpio_sequencer_if bus ();

  led_gpio_sequencer #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int pend_seen  = 0;

  // Background observers, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.gpio_we) strobe_cnt <= strobe_cnt + 1;
    if (bus.pending) pend_seen  <= pend_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Advance until a strobe is visible or the budget runs out.
  task automatic wait_strobe(input int max, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.gpio_we && n < max);
  endtask

  task automatic cpu_write(input logic [31:0] d);
    bus.cpu_we    = 1'b1;
    bus.cpu_wdata = d;
    cycle();
    bus.cpu_we    = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_wdata = d;
    cycle();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic check_engine(input string tag, input logic [7:0] led,
                              input logic [31:0] word);
    int n;
    wait_strobe(3 * TICK_DIV, n);
    check({tag, "_lat"},  n, TICK_DIV);
    check({tag, "_we"},   bus.gpio_we, 1);
    check({tag, "_word"}, bus.gpio_wdata, word);
    check({tag, "_led"},  bus.led_pattern, led);
  endtask

  initial begin
    int s0;
    rst_n         = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_wdata = '0;

    // Reset values
    cycle();
    cycle();
    check("rst_we",      bus.gpio_we, 0);
    check("rst_wdata",   bus.gpio_wdata, 32'h0000_00A8);
    check("rst_led",     bus.led_pattern, 8'h2A);
    check("rst_mode",    bus.mode, 0);
    check("rst_pending", bus.pending, 0);
    rst_n = 1'b1;
    cycle();

    // CPU pass-through in IDLE, one cycle latency, no engine follow-up
    s0 = strobe_cnt;
    cpu_write(32'h1234_5678);
    check("idle_cpu_we",    bus.gpio_we, 1);
    check("idle_cpu_wdata", bus.gpio_wdata, 32'h1234_5678);
    check("idle_cpu_led",   bus.led_pattern, 8'h9E);
    cycle();
    check("idle_we_single", bus.gpio_we, 0);
    repeat (3 * TICK_DIV) cycle();
    check("idle_no_engine", strobe_cnt - s0, 1);

    // Back-to-back CPU stores give back-to-back strobes
    cpu_write(32'h0000_0001);
    check("b2b_1_we",    bus.gpio_we, 1);
    check("b2b_1_wdata", bus.gpio_wdata, 32'h0000_0001);
    cpu_write(32'h0000_0002);
    check("b2b_2_we",    bus.gpio_we, 1);
    check("b2b_2_wdata", bus.gpio_wdata, 32'h0000_0002);

    // Walk from reset: 0x2A -> 0x54 -> 0xA8 -> 0x51
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cfg_write(8'h01);
    check("walk_mode", bus.mode, 2'b01);
    check_engine("walk1", 8'h54, 32'h0000_0150);
    check_engine("walk2", 8'hA8, 32'h0000_02A0);
    check_engine("walk3", 8'h51, 32'h0000_0144);

    // Simultaneous CPU store (LED 0xFF) and config to count, then wrap
    bus.cfg_we    = 1'b1;
    bus.cfg_wdata = 8'hFF;   // reserved bits set, mode 11
    cpu_write(32'hABCD_E7FD);
    bus.cfg_we    = 1'b0;
    check("cnt_cpu_we",    bus.gpio_we, 1);
    check("cnt_cpu_wdata", bus.gpio_wdata, 32'hABCD_E7FD);
    check("cnt_mode",      bus.mode, 2'b11);
    check("cnt_led_ff",    bus.led_pattern, 8'hFF);
    check_engine("cnt_wrap", 8'h00, 32'hABCD_E401);
    check_engine("cnt_inc",  8'h01, 32'hABCD_E405);

    // Blink from 0x0F
    cfg_write(8'h02);
    cpu_write(32'h5500_003C);
    check("blink_cpu_led", bus.led_pattern, 8'h0F);
    check_engine("blink1", 8'hF0, 32'h5500_03C0);
    check_engine("blink2", 8'h0F, 32'h5500_003C);

    // Collision: CPU store on the exact tick edge wins, step discarded
    cfg_write(8'h01);
    repeat (TICK_DIV - 1) cycle();
    cpu_write(32'h0000_0004);
    check("col_cpu_we",    bus.gpio_we, 1);
    check("col_cpu_wdata", bus.gpio_wdata, 32'h0000_0004);
    check("col_cpu_led",   bus.led_pattern, 8'h01);
    check("col_pending",   bus.pending, 0);
    check_engine("col_next", 8'h02, 32'h0000_0008);

    // Reset one cycle before the next tick: no strobe, back to IDLE
    repeat (TICK_DIV - 2) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("mid_rst_we",    bus.gpio_we, 0);
    check("mid_rst_wdata", bus.gpio_wdata, 32'h0000_00A8);
    check("mid_rst_led",   bus.led_pattern, 8'h2A);
    check("mid_rst_mode",  bus.mode, 0);
    s0 = strobe_cnt;
    repeat (3 * TICK_DIV) cycle();
    check("mid_rst_quiet", strobe_cnt - s0, 0);
    check("mid_rst_mode2", bus.mode, 0);

    check("pending_never", pend_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/led_gpio_sequencer.md
# led_gpio_sequencer

Write-port controller for the LED/GPIO output device at 0xF000_0000. Arbitrates that device's single write port between CPU bus stores and an internal LED pattern engine (walk / blink / count). Keeps a shadow of the last word written so engine writes change only the LED field and preserve the GPIO and counter_set fields. Sits between the bus decoder and the LED/GPIO device; its outputs drive the device's write-enable and write-data inputs directly.

## Interface
- TICK_DIV, 25_000_000, clk cycles per pattern step (≥2)
- DIV_W, 25, tick counter width; must hold TICK_DIV-1
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cpu_we  in  1  CPU store to 0xF000_0000 this cycle
- cpu_wdata  in  32  CPU store data
- cfg_we  in  1  write to sequencer config register
- cfg_wdata  in  8  [1:0] mode (00 off, 01 walk, 10 blink, 11 count); [7:2] reserved, ignored
- gpio_we  out  1  write strobe to LED/GPIO device, one cycle per write
- gpio_wdata  out  32  write word: [1:0] counter_set, [9:2] LED image, [31:10] GPIO bits
- led_pattern  out  8  current engine pattern
- pending  out  1  engine step computed but not yet written
- mode  out  2  current mode

## Operation
- Registers: shadow[31:0], led_pattern[7:0], mode[1:0], tick counter, pending flag, gpio_we, gpio_wdata. All outputs registered.
- Reset (rst_n=0 at a rising edge): shadow=gpio_wdata=0x0000_00A8 (LED field 0x2A), led_pattern=0x2A, mode=00, tick=0, pending=0, gpio_we=0. Reset mid-operation drops any pending step and any write not yet issued.
- States: IDLE (mode=00), RUN (mode≠00, counting), PEND (step ready, write slot blocked).
- Config write: mode←cfg_wdata[1:0]; tick←0; pending←0. mode 00 → IDLE, otherwise → RUN. Rewriting the current mode also restarts the tick count.
- Tick: in RUN, tick counts 0..TICK_DIV-1 and wraps. At tick==TICK_DIV-1 compute next = f(led_pattern):
  - walk: rotate left 1; pattern 0x00 → 0x01
  - blink: ~pattern
  - count: pattern+1 mod 256 (0xFF → 0x00)
- Engine write: led_pattern←next; gpio_wdata←{shadow[31:10], next, shadow[1:0]}; gpio_we←1; shadow←that word.
- CPU write (highest priority): gpio_wdata←cpu_wdata; gpio_we←1; shadow←cpu_wdata; led_pattern←cpu_wdata[9:2]; tick←0; pending←0 (a pending engine step is discarded, never overwriting a CPU value); state RUN if mode≠00.
- Collision: can only occur between cpu_we and a tick. CPU wins. The step is discarded per the rule above, so a PEND step exists only when the slot is blocked for a reason other than cpu_we. In this version the CPU is the sole blocker, so PEND is transient: pending is asserted for zero cycles, and the state and pending output are kept for a future second requester. The bench must check that pending=0 at all times.
- cfg_we and cpu_we in the same cycle: both take effect. CPU word is written, mode is updated, tick←0.
- In IDLE no engine writes occur. CPU writes pass through unchanged.

## Timing
- CPU latency: cpu_we at edge N → gpio_we=1 with cpu_wdata during cycle N+1, exactly one cycle.
- First engine write: gpio_we asserted in the cycle after the edge where tick==TICK_DIV-1, i.e. TICK_DIV cycles after the config write edge. Later writes every TICK_DIV cycles.
- gpio_we never high for two consecutive cycles from one event. Back-to-back cpu_we gives back-to-back strobes.
- Outputs change only on rising edges, so they are stable for the device's falling-edge sample.

## Test plan
- Reset: hold rst_n=0 two cycles → gpio_we=0, gpio_wdata=0x0000_00A8, led_pattern=0x2A, mode=00, pending=0.
- CPU pass-through in IDLE: cpu_we with 0x1234_5678 → next cycle gpio_we=1, gpio_wdata=0x1234_5678, led_pattern=0x9E. No further strobes for 3×TICK_DIV cycles.
- Walk mode, TICK_DIV=4, from reset: cfg 0x01 → strobes every 4 cycles with LED field 0x54, 0xA8, 0x51. Bits [31:10] and [1:0] equal shadow.
- Count wrap: CPU writes LED field 0xFF, then cfg 0x03 → next engine write has LED 0x00. Blink from 0x0F gives 0xF0 then 0x0F.
- Collision: cpu_we on the exact tick cycle with 0x0000_0004 → only the CPU strobe appears, LED=0x01. Next engine write follows TICK_DIV cycles later with LED=0x02 (walk). pending stays 0.
- Reset mid-run: assert rst_n=0 one cycle before a tick → no engine strobe, all outputs at reset values, and mode=00 afterwards.
